// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: state encodings,
// error codes, default timing and the on-wire frame builder.
package ps2_host_tx_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_INHIBIT   = 3'd1;
   localparam logic [2:0] ST_REQ       = 3'd2;
   localparam logic [2:0] ST_SHIFT     = 3'd3;
   localparam logic [2:0] ST_ACK       = 3'd4;
   localparam logic [2:0] ST_WAIT_IDLE = 3'd5;
   localparam logic [2:0] ST_DONE      = 3'd6;
   localparam logic [2:0] ST_ERR       = 3'd7;

   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_START_TO = 2'b01;
   localparam logic [1:0] ERR_XFER_TO  = 2'b10;
   localparam logic [1:0] ERR_NO_ACK   = 2'b11;

   localparam int DEF_INHIBIT_CYCLES = 6000;
   localparam int DEF_START_TIMEOUT  = 750000;
   localparam int DEF_XFER_TIMEOUT   = 100000;
   localparam int DEF_FILTER_LEN     = 8;

   // Bits in shift order: data LSB first, odd parity, stop (always 1).
   function automatic logic [9:0] build_frame(input logic [7:0] data);
      return {1'b1, ~^data, data};
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus run-length debounce for a PS/2 pad; emits the
// accepted level and a one-cycle pulse when that level falls.
module ps2_line_filter
   import ps2_host_tx_pkg::*;
#(
   parameter int FILTER_LEN = DEF_FILTER_LEN
) (
   input  logic clk,
   input  logic rst,
   input  logic i_pad,
   output logic o_level,
   output logic o_fall
);

   localparam int CW = $clog2(FILTER_LEN) + 1;

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          fall_q, fall_d;
   logic [CW-1:0] run_q, run_d;

   always_comb begin
      // NOTE: every output gets a default first, so no path leaves one unassigned (no latch).
      level_d = level_q;
      fall_d  = 1'b0;
      run_d   = '0;
      if (sync2_q != level_q) begin
         if (run_q == CW'(FILTER_LEN - 1)) begin
            level_d = sync2_q;
            fall_d  = ~sync2_q;
         end else begin
            run_d = run_q + CW'(1);
         end
      end
   end

   // Idle bus is high, so reset to 1 to avoid a phantom edge after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         fall_q  <= 1'b0;
         run_q   <= '0;
      end else begin
         // NOTE: non-blocking here so the sync chain really is two flops deep.
         sync1_q <= i_pad;
         sync2_q <= sync1_q;
         level_q <= level_d;
         fall_q  <= fall_d;
         run_q   <= run_d;
      end
   end

   assign o_level = level_q;
   assign o_fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, start bit, 10 bits clocked
// out on device falling edges, ACK check, with start and transfer timeouts.
module ps2_host_tx
   import ps2_host_tx_pkg::*;
#(
   parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
   parameter int START_TIMEOUT  = DEF_START_TIMEOUT,
   parameter int XFER_TIMEOUT   = DEF_XFER_TIMEOUT,
   parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
   input  logic       iCLK_50,
   input  logic       iRST,
   input  logic       iSTART,
   input  logic [7:0] iDATA,
   input  logic       iPS2_CLK,
   input  logic       iPS2_DAT,
   output logic       oPS2_CLK_OE,
   output logic       oPS2_DAT_OE,
   output logic       oBUSY,
   output logic       oDONE,
   output logic       oERROR,
   output logic [1:0] oERR_CODE
);

   localparam int T_MAX = (START_TIMEOUT > INHIBIT_CYCLES) ? START_TIMEOUT : INHIBIT_CYCLES;
   localparam int TW    = $clog2(T_MAX + 1);
   localparam int XW    = $clog2(XFER_TIMEOUT + 1);
   localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);
   localparam logic [XW-1:0] XFER_LAST  = XW'(XFER_TIMEOUT - 1);

   logic          clk_level, clk_fall;
   logic          dat_s1_q, dat_sync;
   logic [2:0]    state_q, state_d;
   logic [9:0]    frame_q, frame_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [TW-1:0] timer_q, timer_d, timer_inc;
   logic [XW-1:0] xfer_q, xfer_d, xfer_inc;
   logic          clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
   logic          busy_q, busy_d, done_q, done_d, error_q, error_d;
   logic [1:0]    err_code_q, err_code_d, fail_code;
   logic          shift_bit, fail;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk     (iCLK_50),
      .rst     (iRST),
      .i_pad   (iPS2_CLK),
      .o_level (clk_level),
      .o_fall  (clk_fall)
   );

   // Timers saturate rather than wrap.
   assign timer_inc = (timer_q == '1) ? timer_q : timer_q + TW'(1);
   assign xfer_inc  = (xfer_q  == '1) ? xfer_q  : xfer_q  + XW'(1);

   always_comb begin
      state_d    = state_q;
      frame_d    = frame_q;
      bit_cnt_d  = bit_cnt_q;
      timer_d    = timer_q;
      xfer_d     = xfer_q;
      clk_oe_d   = clk_oe_q;
      dat_oe_d   = dat_oe_q;
      done_d     = 1'b0;
      error_d    = error_q;
      err_code_d = err_code_q;
      shift_bit  = 1'b0;
      fail       = 1'b0;
      fail_code  = ERR_OK;
      case (state_q)
         ST_IDLE: if (iSTART) begin
            frame_d    = build_frame(iDATA);
            bit_cnt_d  = '0;
            timer_d    = '0;
            clk_oe_d   = 1'b1;
            error_d    = 1'b0;
            err_code_d = ERR_OK;
            state_d    = ST_INHIBIT;
         end
         ST_INHIBIT: begin
            timer_d = timer_inc;
            if (dat_oe_q) begin
               clk_oe_d = 1'b0;
               timer_d  = '0;
               state_d  = ST_REQ;
            end else if (timer_q == INH_LAST) begin
               dat_oe_d = 1'b1;
            end
         end
         ST_REQ: begin
            timer_d = timer_inc;
            if (clk_fall) begin
               shift_bit = 1'b1;
               xfer_d    = '0;
               state_d   = ST_SHIFT;
            end else if (timer_q == START_LAST) begin
               fail      = 1'b1;
               fail_code = ERR_START_TO;
            end
         end
         ST_SHIFT: begin
            xfer_d = xfer_inc;
            if (xfer_q == XFER_LAST) begin
               fail      = 1'b1;
               fail_code = ERR_XFER_TO;
            end else if (clk_fall) begin
               shift_bit = 1'b1;
               if (bit_cnt_q == 4'd9) state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            xfer_d = xfer_inc;
            if (xfer_q == XFER_LAST) begin
               fail      = 1'b1;
               fail_code = ERR_XFER_TO;
            end else if (clk_fall) begin
               if (dat_sync) begin
                  fail      = 1'b1;
                  fail_code = ERR_NO_ACK;
               end else begin
                  state_d = ST_WAIT_IDLE;
               end
            end
         end
         ST_WAIT_IDLE: begin
            xfer_d = xfer_inc;
            if (xfer_q == XFER_LAST) begin
               fail      = 1'b1;
               fail_code = ERR_XFER_TO;
            end else if (clk_level && dat_sync) begin
               done_d  = 1'b1;
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;  // DONE and ERR each last exactly one cycle
      endcase

      // Open-drain: a 1 bit is sent by releasing the line.
      if (shift_bit) begin
         dat_oe_d  = ~frame_q[0];
         frame_d   = {1'b1, frame_q[9:1]};
         bit_cnt_d = bit_cnt_q + 4'd1;
      end
      if (fail) begin
         state_d    = ST_ERR;
         clk_oe_d   = 1'b0;
         dat_oe_d   = 1'b0;
         error_d    = 1'b1;
         err_code_d = fail_code;
         done_d     = 1'b1;
      end
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge iCLK_50 or posedge iRST) begin
      if (iRST) begin
         dat_s1_q   <= 1'b1;
         dat_sync   <= 1'b1;
         state_q    <= ST_IDLE;
         frame_q    <= '0;
         bit_cnt_q  <= '0;
         timer_q    <= '0;
         xfer_q     <= '0;
         clk_oe_q   <= 1'b0;
         dat_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         err_code_q <= ERR_OK;
      end else begin
         dat_s1_q   <= iPS2_DAT;
         dat_sync   <= dat_s1_q;
         state_q    <= state_d;
         frame_q    <= frame_d;
         bit_cnt_q  <= bit_cnt_d;
         timer_q    <= timer_d;
         xfer_q     <= xfer_d;
         clk_oe_q   <= clk_oe_d;
         dat_oe_q   <= dat_oe_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         err_code_q <= err_code_d;
      end
   end

   // Pad enables come straight from flops, so the bus never sees decode glitches.
   assign oPS2_CLK_OE = clk_oe_q;
   assign oPS2_DAT_OE = dat_oe_q;
   assign oBUSY       = busy_q;
   assign oDONE       = done_q;
   assign oERROR      = error_q;
   assign oERR_CODE   = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural PS/2 device model,
// random command bytes and a frame/error reference computed from the protocol.
module tb_ps2_host_tx;

   localparam int INH      = 60;
   localparam int START_TO = 3000;
   localparam int XFER_TO  = 1500;
   localparam int FLT      = 8;
   localparam int HALF     = 40;

   logic       clk = 1'b0;
   logic       rst, start;
   logic [7:0] data;
   logic       clk_oe, dat_oe, busy, done, error;
   logic [1:0] code;
   logic       dev_clk_low, dev_dat_low;
   logic       ps2_clk, ps2_dat;

   assign ps2_clk = ~(clk_oe | dev_clk_low);
   assign ps2_dat = ~(dat_oe | dev_dat_low);

   always #10 clk = ~clk;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .START_TIMEOUT  (START_TO),
      .XFER_TIMEOUT   (XFER_TO),
      .FILTER_LEN     (FLT)
   ) dut (
      .iCLK_50     (clk),
      .iRST        (rst),
      .iSTART      (start),
      .iDATA       (data),
      .iPS2_CLK    (ps2_clk),
      .iPS2_DAT    (ps2_dat),
      .oPS2_CLK_OE (clk_oe),
      .oPS2_DAT_OE (dat_oe),
      .oBUSY       (busy),
      .oDONE       (done),
      .oERROR      (error),
      .oERR_CODE   (code)
   );

   int unsigned cyc = 0;
   int unsigned done_total = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (done) done_total <= done_total + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected on-wire bits in send order: data LSB first, odd parity, stop.
   function automatic logic [9:0] ref_frame(input logic [7:0] d);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
   endfunction

   logic [9:0]  rx;
   int unsigned release_cyc, first_fall_cyc, done_cyc;
   int          clk_only, overlap;
   bit          got_done;
   logic        done_err, done_busy;
   logic [1:0]  done_code, done_oe;

   task automatic device_run(input int n_clk, input bit ack, input bit glitch,
                             input bit mid_start, input logic [7:0] d);
      int g = 0;
      clk_only = 0;
      overlap  = 0;
      rx       = '0;
      while (!clk_oe && g < 100) begin @(negedge clk); g++; end
      check("inhibit_begin", 32'(clk_oe), 32'd1);
      g = 0;
      while (clk_oe && g < INH + 100) begin
         if (dat_oe) overlap++; else clk_only++;
         @(negedge clk);
         g++;
      end
      release_cyc = cyc;
      check("inhibit_len", 32'(clk_only), 32'(INH));
      check("start_overlap", 32'(overlap), 32'd1);
      check("start_bit", 32'(dat_oe), 32'd1);
      repeat ($urandom_range(20, 100)) @(negedge clk);
      for (int k = 1; k <= n_clk; k++) begin
         if (k == 11 && ack) begin
            dev_dat_low = 1'b1;
            repeat (5) @(negedge clk);
         end
         dev_clk_low = 1'b1;
         if (k == 1) first_fall_cyc = cyc;
         repeat (HALF) @(negedge clk);
         if (k == 6 && mid_start) begin
            start = 1'b1;
            data  = ~d;
            @(negedge clk);
            start = 1'b0;
            data  = d;
         end
         if (k <= 10) rx[k-1] = ps2_dat;
         dev_clk_low = 1'b0;
         if (k == 11 && ack) begin
            repeat (5) @(negedge clk);
            dev_dat_low = 1'b0;
         end
         if (k == 4 && glitch) begin
            repeat (10) @(negedge clk);
            dev_clk_low = 1'b1;
            @(negedge clk);
            dev_clk_low = 1'b0;
         end
         repeat (HALF) @(negedge clk);
      end
   endtask

   task automatic wait_done(input int budget, input bit start_on_done);
      int n = 0;
      got_done = 1'b0;
      while (!done && n < budget) begin @(negedge clk); n++; end
      if (done) begin
         got_done  = 1'b1;
         done_cyc  = cyc;
         done_err  = error;
         done_code = code;
         done_oe   = {clk_oe, dat_oe};
         done_busy = busy;
         if (start_on_done) begin
            start = 1'b1;
            data  = 8'hA5;
         end
         @(negedge clk);
         start = 1'b0;
         check("done_width", 32'(done), 32'd0);
      end
      check("done_seen", 32'(got_done), 32'd1);
   endtask

   task automatic run_txn(input logic [7:0] d, input int n_clk, input bit ack, input bit glitch,
                          input bit mid_start, input bit start_on_done, input logic [1:0] exp_code);
      int unsigned done_before;
      int          busy_hits = 0;
      int unsigned delta;
      @(negedge clk);
      data  = d;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("err_cleared", 32'({error, code}), 32'd0);
      check("busy_after_start", 32'(busy), 32'd1);
      done_before = done_total;
      fork
         device_run(n_clk, ack, glitch, mid_start, d);
         wait_done(START_TO + XFER_TO + 3000, start_on_done);
      join
      check($sformatf("code_%02h", d), 32'(done_code), 32'(exp_code));
      check("error_flag", 32'(done_err), 32'(exp_code != 2'b00));
      check("oe_at_done", 32'(done_oe), 32'd0);
      check("busy_at_done", 32'(done_busy), 32'd1);
      if (n_clk >= 10) check($sformatf("frame_%02h", d), 32'(rx), 32'(ref_frame(d)));
      if (exp_code == 2'b01) begin
         delta = done_cyc - release_cyc;
         check($sformatf("start_to_window_%0d", delta), 32'(delta >= START_TO && delta <= START_TO + 4), 32'd1);
      end
      if (exp_code == 2'b10) begin
         delta = done_cyc - first_fall_cyc;
         check($sformatf("xfer_to_window_%0d", delta), 32'(delta >= XFER_TO && delta <= XFER_TO + 30), 32'd1);
      end
      repeat (20) begin
         @(negedge clk);
         if (busy) busy_hits++;
      end
      check("idle_after_done", 32'(busy_hits), 32'd0);
      check("done_count", done_total - done_before, 32'd1);
      if (exp_code != 2'b00) check("error_held", 32'({error, code}), 32'({1'b1, exp_code}));
   endtask

   task automatic reset_mid_shift();
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      @(negedge clk);
      data  = d;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      device_run(3, 1'b0, 1'b0, 1'b0, d);
      check("busy_before_rst", 32'(busy), 32'd1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("rst_clk_oe", 32'(clk_oe), 32'd0);
      check("rst_dat_oe", 32'(dat_oe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("post_rst_idle", 32'({busy, clk_oe, dat_oe, done}), 32'd0);
   endtask

   initial begin
      #1_600_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      data        = 8'h00;
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_clk_oe", 32'(clk_oe), 32'd0);
      check("rst_dat_oe", 32'(dat_oe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_code", 32'(code), 32'd0);
      rst = 1'b0;
      repeat (30) @(negedge clk);

      run_txn(8'hED, 11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      run_txn(8'h00, 11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      run_txn(8'hFF, 11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      for (int i = 0; i < 6; i++)
         run_txn(8'($urandom_range(0, 255)), 11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);

      run_txn(8'($urandom_range(0, 255)), 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
      run_txn(8'($urandom_range(0, 255)), 5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
      run_txn(8'($urandom_range(0, 255)), 11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
      run_txn(8'hED, 11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);

      run_txn(8'($urandom_range(0, 255)), 11, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00);

      reset_mid_shift();
      run_txn(8'($urandom_range(0, 255)), 11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
